// File: rtl/load_hazard_scheduler.sv
// load_hazard_scheduler
//   Issue controller between the decoder and the execute stage. A 32-bit
//   scoreboard tracks the destination registers of loads in flight. Decode
//   stalls on load-use (RAW) and load-load (WAW) hazards, and when the number
//   of outstanding loads reaches MAX_LOADS. A store-conditional waits until
//   every outstanding load has drained before it issues. ALU results are
//   forwarded, so only lw, ll and the sc result are entered in the scoreboard.
//
// Ports
//   clk_i, rst_i          core clock and asynchronous active-high reset
//   dec_*_i               decode-stage instruction description
//   ex_ready_i            execute stage can accept an instruction
//   flush_i               kill the decode-stage instruction
//   mem_done_i/_rw_i      one load/sc completed, with its destination (0 = none)
//   issue_valid_o         instruction handed to execute this cycle (comb)
//   dec_stall_o           hold fetch/decode registers (comb)
//   pending_o             scoreboard, bit n = load to register n in flight
//   outstanding_o         number of loads in flight
//   drain_busy_o          sc is waiting for outstanding loads to drain
//   proto_err_o           sticky: mem_done seen with no load outstanding
module load_hazard_scheduler #(
  parameter int MAX_LOADS = 2,
  parameter int CNT_W     = $clog2(MAX_LOADS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             dec_valid_i,
  input  logic             dec_uses_rs_i,
  input  logic [4:0]       dec_rs_addr_i,
  input  logic             dec_uses_rt_i,
  input  logic [4:0]       dec_rt_addr_i,
  input  logic             dec_uses_rw_i,
  input  logic [4:0]       dec_rw_addr_i,
  input  logic             dec_is_load_i,
  input  logic             dec_is_sc_i,
  input  logic             ex_ready_i,
  input  logic             flush_i,
  input  logic             mem_done_i,
  input  logic [4:0]       mem_done_rw_i,
  output logic             issue_valid_o,
  output logic             dec_stall_o,
  output logic [31:0]      pending_o,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             drain_busy_o,
  output logic             proto_err_o
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pending_q, pending_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             proto_err_q, proto_err_d;

  logic [31:0] done_mask;
  logic [31:0] set_mask;
  logic [31:0] pend_eff;
  logic        mem_inst;
  logic        at_max;
  logic        any_out;
  logic        hazard;
  logic        issue;
  logic        inc;
  logic        dec;

  assign mem_inst = dec_is_load_i | dec_is_sc_i;
  assign at_max   = (outstanding_q == CNT_W'(MAX_LOADS));
  assign any_out  = (outstanding_q != {CNT_W{1'b0}});

  // Same-cycle completion bypasses the scoreboard so it costs no stall cycle.
  always_comb begin
    done_mask = 32'd0;
    if (mem_done_i) begin
      done_mask = 32'd1 << mem_done_rw_i;
    end else begin
      done_mask = 32'd0;
    end
    pend_eff = pending_q & ~done_mask;
  end

  // Hazard detection and issue decision.
  always_comb begin
    hazard = (dec_uses_rs_i & pend_eff[dec_rs_addr_i])
           | (dec_uses_rt_i & pend_eff[dec_rt_addr_i])
           | (dec_uses_rw_i & pend_eff[dec_rw_addr_i])
           | (mem_inst & at_max & ~mem_done_i);
    issue  = dec_valid_i & ~flush_i & ~hazard & ex_ready_i
           & (state_q == ST_RUN) & ~(dec_is_sc_i & any_out);
  end

  assign issue_valid_o = issue;
  assign dec_stall_o   = dec_valid_i & ~flush_i & ~issue;

  // sc serialisation FSM: a killed sc never enters DRAIN, and flush leaves it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (dec_valid_i && dec_is_sc_i && any_out && !flush_i) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (flush_i || !any_out ||
            (mem_done_i && outstanding_q == CNT_W'(1))) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Scoreboard and counter next state. Set beats clear on the same register.
  always_comb begin
    inc = issue & mem_inst;
    dec = mem_done_i & any_out;
    if (issue && mem_inst && dec_uses_rw_i) begin
      set_mask = 32'd1 << dec_rw_addr_i;
    end else begin
      set_mask = 32'd0;
    end
    pending_d    = (pending_q & ~done_mask) | set_mask;
    pending_d[0] = 1'b0;
    if (inc && !dec) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (dec && !inc) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end else begin
      outstanding_d = outstanding_q;
    end
    proto_err_d = proto_err_q | (mem_done_i & ~any_out);
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      pending_q     <= 32'd0;
      outstanding_q <= {CNT_W{1'b0}};
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign pending_o     = pending_q;
  assign outstanding_o = outstanding_q;
  assign drain_busy_o  = (state_q == ST_DRAIN);
  assign proto_err_o   = proto_err_q;

endmodule

// File: tb/tb_load_hazard_scheduler.sv
module tb_load_hazard_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_uses_rs, dec_uses_rt, dec_uses_rw;
  logic [4:0]  dec_rs_addr, dec_rt_addr, dec_rw_addr;
  logic        dec_is_load, dec_is_sc, ex_ready, flush, mem_done;
  logic [4:0]  mem_done_rw;
  logic        issue_valid, dec_stall, drain_busy, proto_err;
  logic [31:0] pending;
  logic [1:0]  outstanding;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_hazard_scheduler #(.MAX_LOADS(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .dec_valid_i(dec_valid),
    .dec_uses_rs_i(dec_uses_rs), .dec_rs_addr_i(dec_rs_addr),
    .dec_uses_rt_i(dec_uses_rt), .dec_rt_addr_i(dec_rt_addr),
    .dec_uses_rw_i(dec_uses_rw), .dec_rw_addr_i(dec_rw_addr),
    .dec_is_load_i(dec_is_load), .dec_is_sc_i(dec_is_sc),
    .ex_ready_i(ex_ready), .flush_i(flush),
    .mem_done_i(mem_done), .mem_done_rw_i(mem_done_rw),
    .issue_valid_o(issue_valid), .dec_stall_o(dec_stall),
    .pending_o(pending), .outstanding_o(outstanding),
    .drain_busy_o(drain_busy), .proto_err_o(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a decode instruction, then let combinational outputs settle.
  task automatic set_dec(input logic v, input logic urs, input logic [4:0] rs,
                         input logic urt, input logic [4:0] rt,
                         input logic urw, input logic [4:0] rw,
                         input logic ld, input logic sc);
    dec_valid = v;  dec_uses_rs = urs; dec_rs_addr = rs;
    dec_uses_rt = urt; dec_rt_addr = rt;
    dec_uses_rw = urw; dec_rw_addr = rw;
    dec_is_load = ld; dec_is_sc = sc;
    #1;
  endtask

  task automatic set_done(input logic d, input logic [4:0] rw);
    mem_done = d; mem_done_rw = rw;
    #1;
  endtask

  initial begin
    rst = 1'b1; ex_ready = 1'b1; flush = 1'b0;
    mem_done = 1'b0; mem_done_rw = 5'd0;
    set_dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_pending", pending, 32'd0);
    chk("rst_outstanding", {30'd0, outstanding}, 32'd0);
    chk("rst_drain", {31'd0, drain_busy}, 32'd0);
    chk("rst_proto", {31'd0, proto_err}, 32'd0);
    chk("rst_issue", {31'd0, issue_valid}, 32'd0);
    chk("rst_stall", {31'd0, dec_stall}, 32'd0);

    // lw r8 ; add r9,r8,r8 (RAW) ; completion of r8 bypasses
    step();
    set_dec(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
    chk("lw8_issue", {31'd0, issue_valid}, 32'd1);
    step();
    set_dec(1'b1, 1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b0, 1'b0);
    chk("raw_pending", pending, 32'h0000_0100);
    chk("raw_stall", {31'd0, dec_stall}, 32'd1);
    chk("raw_noissue", {31'd0, issue_valid}, 32'd0);
    step();
    set_done(1'b1, 5'd8);
    chk("bypass_issue", {31'd0, issue_valid}, 32'd1);
    chk("bypass_stall", {31'd0, dec_stall}, 32'd0);
    step();
    set_done(1'b0, 5'd0);
    set_dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("bypass_pending", pending, 32'd0);
    chk("bypass_out", {30'd0, outstanding}, 32'd0);

    // Three back-to-back loads with MAX_LOADS=2
    set_dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);
    chk("ld1_issue", {31'd0, issue_valid}, 32'd1);
    step();
    set_dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0);
    chk("ld2_issue", {31'd0, issue_valid}, 32'd1);
    step();
    set_dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
    chk("ld3_out", {30'd0, outstanding}, 32'd2);
    chk("ld3_stall", {31'd0, dec_stall}, 32'd1);
    step();
    set_done(1'b1, 5'd1);
    chk("ld3_issue_on_done", {31'd0, issue_valid}, 32'd1);
    step();
    set_done(1'b0, 5'd0);
    set_dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("ld3_out_after", {30'd0, outstanding}, 32'd2);
    chk("ld3_pending", pending, 32'h0000_000C);
    set_done(1'b1, 5'd2);
    step();
    set_done(1'b1, 5'd3);
    step();
    set_done(1'b0, 5'd0);
    chk("drain3_out", {30'd0, outstanding}, 32'd0);
    chk("drain3_pending", pending, 32'd0);

    // Two loads then sc: DRAIN until both complete
    set_dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    step();
    set_dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    set_dec(1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b1);
    chk("sc_stall_run", {31'd0, dec_stall}, 32'd1);
    chk("sc_noissue_run", {31'd0, issue_valid}, 32'd0);
    step();
    chk("sc_drain", {31'd0, drain_busy}, 32'd1);
    set_done(1'b1, 5'd4);
    chk("sc_stall_d1", {31'd0, dec_stall}, 32'd1);
    step();
    chk("sc_drain_still", {31'd0, drain_busy}, 32'd1);
    chk("sc_out_1", {30'd0, outstanding}, 32'd1);
    set_done(1'b1, 5'd5);
    chk("sc_stall_d2", {31'd0, dec_stall}, 32'd1);
    step();
    set_done(1'b0, 5'd0);
    chk("sc_run_again", {31'd0, drain_busy}, 32'd0);
    chk("sc_issue", {31'd0, issue_valid}, 32'd1);
    step();
    set_dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("sc_out_after", {30'd0, outstanding}, 32'd1);
    chk("sc_pending", pending, 32'h0000_0080);
    set_done(1'b1, 5'd7);
    step();
    set_done(1'b0, 5'd0);
    chk("sc_done_out", {30'd0, outstanding}, 32'd0);

    // lw r0: counted but not scoreboarded
    set_dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("lw0_issue", {31'd0, issue_valid}, 32'd1);
    step();
    set_dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("lw0_out", {30'd0, outstanding}, 32'd1);
    chk("lw0_pending", pending, 32'd0);
    set_done(1'b1, 5'd0);
    step();
    chk("lw0_done_out", {30'd0, outstanding}, 32'd0);
    chk("lw0_no_proto", {31'd0, proto_err}, 32'd0);

    // Spurious completion -> sticky protocol error, no wrap
    step();
    set_done(1'b0, 5'd0);
    chk("proto_set", {31'd0, proto_err}, 32'd1);
    chk("proto_out", {30'd0, outstanding}, 32'd0);
    step(); step();
    chk("proto_hold", {31'd0, proto_err}, 32'd1);

    // Stalled RAW consumer killed by flush, then async reset
    set_dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);
    step();
    set_dec(1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b1, 5'd11, 1'b0, 1'b0);
    chk("flush_pre_stall", {31'd0, dec_stall}, 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_issue", {31'd0, issue_valid}, 32'd0);
    chk("flush_stall", {31'd0, dec_stall}, 32'd0);
    step();
    flush = 1'b0;
    set_dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("flush_pending", pending, 32'h0000_0400);
    chk("flush_out", {30'd0, outstanding}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_pending", pending, 32'd0);
    chk("arst_out", {30'd0, outstanding}, 32'd0);
    chk("arst_proto", {31'd0, proto_err}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_pending", pending, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
